// File: rtl/fx_round_pipe_if.sv
// -----------------------------------------------------------------------------
// fx_round_pipe_if
// Stream bundle for fx_round_pipe: an input stream (din + mode) and an output
// stream (dout + sat), each with its own valid/ready pair.
//
// Parameters:
//   DIN_W  - width of the signed fixed-point input sample
//   DOUT_W - width of the signed rounded output
//
// Signals:
//   in_valid / in_ready   - input handshake
//   din, mode             - sample and its per-sample rounding mode
//   out_valid / out_ready - output handshake
//   dout, sat             - rounded result and saturation flag
//
// Modports:
//   master - the side that produces samples and consumes results
//   slave  - the rounding unit itself
// -----------------------------------------------------------------------------
interface fx_round_pipe_if #(
    parameter int DIN_W  = 16,
    parameter int DOUT_W = 12
);
    logic              in_valid;
    logic              in_ready;
    logic [DIN_W-1:0]  din;
    logic [2:0]        mode;
    logic              out_valid;
    logic              out_ready;
    logic [DOUT_W-1:0] dout;
    logic              sat;

    modport master (
        output in_valid, din, mode, out_ready,
        input  in_ready, out_valid, dout, sat
    );

    modport slave (
        input  in_valid, din, mode, out_ready,
        output in_ready, out_valid, dout, sat
    );
endinterface

// File: rtl/fx_round_pipe.sv
// -----------------------------------------------------------------------------
// fx_round_pipe
// Two-stage pipelined fixed-point rounding unit. A signed sample with FRAC_W
// fractional bits is reduced to a signed DOUT_W-bit integer using one of six
// rounding modes (selected per sample), then saturated to the output range.
//
//   mode 0 floor, 1 ceil, 2 half-up, 3 half away from zero, 4 half-to-even,
//   5 truncate toward zero, 6/7 behave as floor.
//
// Ports:
//   clk     - clock, all state updates on the rising edge
//   rst_n   - synchronous active-low reset
//   bus     - fx_round_pipe_if.slave (input stream din/mode, output dout/sat)
//   sat_cnt - 16-bit saturating count of output transfers with sat = 1
//             (present only when FX_ROUND_SAT_CNT_EN is defined)
//
// Optional feature macro: FX_ROUND_SAT_CNT_EN
//
// Stage 1 holds the integer part and the increment decision; stage 2 holds the
// saturated result. Each stage loads when empty or when its consumer drains it,
// so bubbles collapse and throughput is one sample per cycle.
// -----------------------------------------------------------------------------
module fx_round_pipe #(
    parameter int DIN_W  = 16,
    parameter int FRAC_W = 4,
    parameter int DOUT_W = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    fx_round_pipe_if.slave      bus
`ifdef FX_ROUND_SAT_CNT_EN
    ,
    output logic [15:0]         sat_cnt
`endif
);

    localparam int IP_W = DIN_W - FRAC_W;   // integer part width
    localparam int R_W  = IP_W + 1;         // ip + inc can never overflow here

    localparam logic [FRAC_W-1:0] HALF = FRAC_W'(1) << (FRAC_W - 1);

    // Output limits expressed at the sum width so the compare is a plain
    // signed compare regardless of how much headroom DOUT_W leaves.
    localparam logic signed [R_W-1:0] MAX_R =
        {{(R_W - DOUT_W + 1){1'b0}}, {(DOUT_W - 1){1'b1}}};
    localparam logic signed [R_W-1:0] MIN_R =
        {{(R_W - DOUT_W + 1){1'b1}}, {(DOUT_W - 1){1'b0}}};

    // ------------------------------------------------------------------
    // Stage 1 combinational: split the sample and decide the increment
    // ------------------------------------------------------------------
    logic [IP_W-1:0]   ip;
    logic [FRAC_W-1:0] fr;
    logic              sgn;
    logic              fr_nz;
    logic              fr_ge_h;
    logic              fr_gt_h;
    logic              fr_eq_h;
    logic [7:0]        inc_by_mode;
    logic              inc_next;

    // Taking the upper bits of a two's-complement word is the arithmetic floor.
    assign ip      = bus.din[DIN_W-1:FRAC_W];
    assign fr      = bus.din[FRAC_W-1:0];
    assign sgn     = bus.din[DIN_W-1];
    assign fr_nz   = |fr;
    assign fr_ge_h = (fr >= HALF);
    assign fr_gt_h = (fr >  HALF);
    assign fr_eq_h = (fr == HALF);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_mode
            if (gi == 1) begin : g_ceil
                assign inc_by_mode[gi] = fr_nz;
            end else if (gi == 2) begin : g_half_up
                assign inc_by_mode[gi] = fr_ge_h;
            end else if (gi == 3) begin : g_half_away
                // A negative tie is already rounded away by the floor.
                assign inc_by_mode[gi] = fr_gt_h | (fr_eq_h & ~sgn);
            end else if (gi == 4) begin : g_half_even
                // On a tie, step up only when the floor is odd.
                assign inc_by_mode[gi] = fr_gt_h | (fr_eq_h & ip[0]);
            end else if (gi == 5) begin : g_trunc
                // Floor already truncates positives; negatives need +1.
                assign inc_by_mode[gi] = sgn & fr_nz;
            end else begin : g_floor
                assign inc_by_mode[gi] = 1'b0;
            end
        end
    endgenerate

    assign inc_next = inc_by_mode[bus.mode];

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic s1_valid_reg;
    logic out_valid_reg;
    logic s2_ld;
    logic in_ready;
    logic in_take;

    assign s2_ld    = ~out_valid_reg | bus.out_ready;
    assign in_ready = rst_n & (~s1_valid_reg | s2_ld);
    assign in_take  = in_ready & bus.in_valid;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_reg;

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic [IP_W-1:0] s1_ip_reg;
    logic            s1_inc_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
        end else if (in_ready) begin
            // Stage 1 is empty or is being drained this cycle.
            s1_valid_reg <= bus.in_valid;
        end
    end

    // Payload needs no reset: it is qualified by s1_valid_reg.
    always_ff @(posedge clk) begin
        if (in_take) begin
            s1_ip_reg  <= ip;
            s1_inc_reg <= inc_next;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: add and saturate
    // ------------------------------------------------------------------
    logic signed [R_W-1:0] r_sum;
    logic                  sat_hi;
    logic                  sat_lo;
    logic [DOUT_W-1:0]     dout_next;
    logic                  sat_next;

    assign r_sum  = $signed({s1_ip_reg[IP_W-1], s1_ip_reg} + R_W'(s1_inc_reg));
    assign sat_hi = (r_sum > MAX_R);
    assign sat_lo = (r_sum < MIN_R);

    always_comb begin
        dout_next = r_sum[DOUT_W-1:0];
        sat_next  = 1'b0;
        if (sat_hi) begin
            dout_next = MAX_R[DOUT_W-1:0];
            sat_next  = 1'b1;
        end else if (sat_lo) begin
            dout_next = MIN_R[DOUT_W-1:0];
            sat_next  = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 registers
    // ------------------------------------------------------------------
    logic [DOUT_W-1:0] dout_reg;
    logic              sat_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            dout_reg      <= '0;
            sat_reg       <= 1'b0;
        end else if (s2_ld) begin
            out_valid_reg <= s1_valid_reg;
            // Hold the last result across bubbles rather than loading junk.
            if (s1_valid_reg) begin
                dout_reg <= dout_next;
                sat_reg  <= sat_next;
            end
        end
    end

    assign bus.dout = dout_reg;
    assign bus.sat  = sat_reg;

`ifdef FX_ROUND_SAT_CNT_EN
    // ------------------------------------------------------------------
    // Saturation event counter: counts delivered saturated results only,
    // sticks at all-ones.
    // ------------------------------------------------------------------
    logic [15:0] sat_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_cnt_reg <= '0;
        end else if (out_valid_reg && bus.out_ready && sat_reg
                     && (sat_cnt_reg != 16'hFFFF)) begin
            sat_cnt_reg <= sat_cnt_reg + 16'd1;
        end
    end

    assign sat_cnt = sat_cnt_reg;
`endif

endmodule
